// File: rtl/hpdmc_wrseq_ddr16.sv
// Write-burst sequencer for the 16-bit DDR data pads: waits the write latency,
// then drives preamble, data and postamble into the DQ/DM/DQS output registers.
module hpdmc_wrseq_ddr16 #(
    parameter int WL          = 2,
    parameter int BURST_BEATS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        write,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic        wdata_req,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [15:0] dq_d0,
    output logic [15:0] dq_d1,
    output logic [1:0]  dm_d0,
    output logic [1:0]  dm_d1,
    output logic        dqs_d0,
    output logic        dqs_d1,
    output logic        dq_oe,
    output logic        dqs_oe
);

    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam bit HAS_WAIT = (WL > 1);
    localparam logic [3:0]    WAIT_INIT = 4'((WL > 1) ? (WL - 2) : 0);
    localparam logic [BW-1:0] BEAT_INIT = BW'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_DATA,
        S_POST
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic          accept;

    // Counters hold the number of cycles still to go after the current one.
    always_comb begin
        accept    = write & ready;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        case (state)
            S_IDLE, S_POST: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (HAS_WAIT) begin
                        state_nxt = S_WAIT;
                        wait_nxt  = WAIT_INIT;
                    end else begin
                        state_nxt = S_PRE;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_PRE;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            S_PRE: begin
                state_nxt = S_DATA;
                beat_nxt  = BEAT_INIT;
            end
            S_DATA: begin
                if (beat_cnt == '0) begin
                    state_nxt = S_POST;
                end else begin
                    beat_nxt = beat_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            beat_cnt  <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            wdata_req <= 1'b0;
            dq_d0     <= 16'h0000;
            dq_d1     <= 16'h0000;
            dm_d0     <= 2'b11;
            dm_d1     <= 2'b11;
            dqs_d0    <= 1'b0;
            dqs_d1    <= 1'b0;
            dq_oe     <= 1'b0;
            dqs_oe    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            beat_cnt  <= beat_nxt;
            ready     <= (state_nxt == S_IDLE) || (state_nxt == S_POST);
            done      <= (state_nxt == S_POST);
            err       <= err | (write & ~ready);
            wdata_req <= (state_nxt == S_PRE) ||
                         ((state_nxt == S_DATA) && (beat_nxt != '0));
            dqs_d0    <= (state_nxt == S_DATA);
            dqs_d1    <= 1'b0;
            dq_oe     <= (state_nxt == S_DATA);
            dqs_oe    <= (state_nxt == S_PRE) || (state_nxt == S_DATA) ||
                         (state_nxt == S_POST);
            if (state_nxt == S_DATA) begin
                dq_d0 <= wdata[31:16];
                dq_d1 <= wdata[15:0];
                dm_d0 <= wmask[3:2];
                dm_d1 <= wmask[1:0];
            end else begin
                dq_d0 <= 16'h0000;
                dq_d1 <= 16'h0000;
                dm_d0 <= 2'b11;
                dm_d1 <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_hpdmc_wrseq_ddr16.sv
// Directed bench for hpdmc_wrseq_ddr16: a WL=2 instance fed by a FWFT buffer
// model, plus a WL=1 instance for the zero-wait path.
module tb_hpdmc_wrseq_ddr16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, write, buf_clr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ready, done, err, wdata_req, dqs_d0, dqs_d1, dq_oe, dqs_oe;
    logic [15:0] dq_d0, dq_d1;
    logic [1:0]  dm_d0, dm_d1;

    logic        rst1_n, write1;
    logic [31:0] wdata1;
    logic [3:0]  wmask1;
    logic        ready1, done1, err1, wdata_req1, dqs_d0_1, dqs_d1_1, dq_oe1, dqs_oe1;
    logic [15:0] dq_d0_1, dq_d1_1;
    logic [1:0]  dm_d0_1, dm_d1_1;

    logic [31:0] buf_data [0:31];
    logic [3:0]  buf_mask [0:31];
    logic [31:0] exp_w [0:7];
    logic [4:0]  rd_ptr;
    int          pops;
    int          checks = 0;
    int          errors = 0;

    assign wdata = buf_data[rd_ptr];
    assign wmask = buf_mask[rd_ptr];

    always @(posedge clk) begin
        if (buf_clr) begin
            rd_ptr <= 5'd0;
            pops   <= 0;
        end else if (wdata_req) begin
            rd_ptr <= rd_ptr + 5'd1;
            pops   <= pops + 1;
        end
    end

    hpdmc_wrseq_ddr16 #(.WL(2), .BURST_BEATS(4)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .write(write), .ready(ready),
        .done(done), .err(err), .wdata_req(wdata_req), .wdata(wdata),
        .wmask(wmask), .dq_d0(dq_d0), .dq_d1(dq_d1), .dm_d0(dm_d0),
        .dm_d1(dm_d1), .dqs_d0(dqs_d0), .dqs_d1(dqs_d1), .dq_oe(dq_oe),
        .dqs_oe(dqs_oe)
    );

    hpdmc_wrseq_ddr16 #(.WL(1), .BURST_BEATS(4)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst1_n), .write(write1), .ready(ready1),
        .done(done1), .err(err1), .wdata_req(wdata_req1), .wdata(wdata1),
        .wmask(wmask1), .dq_d0(dq_d0_1), .dq_d1(dq_d1_1), .dm_d0(dm_d0_1),
        .dm_d1(dm_d1_1), .dqs_d0(dqs_d0_1), .dqs_d1(dqs_d1_1), .dq_oe(dq_oe1),
        .dqs_oe(dqs_oe1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_buf(input int n);
        buf_clr = 1'b1;
        tick();
        buf_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            buf_data[i] = exp_w[i];
            buf_mask[i] = 4'b0000;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; write = 1'b0; rst1_n = 1'b0; write1 = 1'b0; buf_clr = 1'b1;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++;
        if ({done, err, wdata_req, dq_oe, dqs_oe} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {done, err, wdata_req, dq_oe, dqs_oe});
        end
        checks++;
        if ({dq_d0, dq_d1, dqs_d0, dqs_d1} !== 34'd0) begin
            errors++; $display("FAIL reset_dq got %h want 0", {dq_d0, dq_d1, dqs_d0, dqs_d1});
        end
        checks++;
        if ({dm_d0, dm_d1} !== 4'b1111) begin
            errors++; $display("FAIL reset_dm got %b want 1111", {dm_d0, dm_d1});
        end
        checks++;
        if ({ready1, dq_oe1, dqs_oe1, dm_d0_1} !== 5'b10011) begin
            errors++; $display("FAIL reset_dut1 got %b want 10011", {ready1, dq_oe1, dqs_oe1, dm_d0_1});
        end
        rst_n = 1'b1; rst1_n = 1'b1; buf_clr = 1'b0;
        tick();
        // write coinciding with reset must be lost
        rst_n = 1'b0; write = 1'b1;
        tick();
        rst_n = 1'b1; write = 1'b0;
        tick();
        checks++;
        if ({ready, dqs_oe, wdata_req} !== 3'b100) begin
            errors++; $display("FAIL reset_wins got %b want 100", {ready, dqs_oe, wdata_req});
        end
        tick();
        checks++;
        if (pops !== 0) begin errors++; $display("FAIL reset_wins_pops got %0d want 0", pops); end
    endtask

    task automatic test_single_burst;
        exp_w[0] = 32'h11112222; exp_w[1] = 32'h33334444;
        exp_w[2] = 32'h55556666; exp_w[3] = 32'h77778888;
        load_buf(4);
        write = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic e_rdy, e_req, e_dqoe, e_dqsoe, e_done;
            logic [31:0] e_dq;
            logic [3:0]  e_dm;
            e_rdy   = (c == 0) || (c >= 7);
            e_req   = (c >= 2) && (c <= 5);
            e_dqoe  = (c >= 3) && (c <= 6);
            e_dqsoe = (c >= 2) && (c <= 7);
            e_done  = (c == 7);
            e_dq    = e_dqoe ? exp_w[c-3] : 32'h0;
            e_dm    = e_dqoe ? 4'b0000 : 4'b1111;
            checks++;
            if (ready !== e_rdy) begin errors++; $display("FAIL sb_ready c%0d got %b want %b", c, ready, e_rdy); end
            checks++;
            if (wdata_req !== e_req) begin errors++; $display("FAIL sb_req c%0d got %b want %b", c, wdata_req, e_req); end
            checks++;
            if ({dq_oe, dqs_oe, dqs_d0} !== {e_dqoe, e_dqsoe, e_dqoe}) begin
                errors++; $display("FAIL sb_oe c%0d got %b want %b", c, {dq_oe, dqs_oe, dqs_d0}, {e_dqoe, e_dqsoe, e_dqoe});
            end
            checks++;
            if (done !== e_done) begin errors++; $display("FAIL sb_done c%0d got %b want %b", c, done, e_done); end
            checks++;
            if ({dq_d0, dq_d1} !== e_dq) begin errors++; $display("FAIL sb_dq c%0d got %h want %h", c, {dq_d0, dq_d1}, e_dq); end
            checks++;
            if ({dm_d0, dm_d1} !== e_dm) begin errors++; $display("FAIL sb_dm c%0d got %b want %b", c, {dm_d0, dm_d1}, e_dm); end
            tick();
            write = 1'b0;
        end
        checks++;
        if (pops !== 4) begin errors++; $display("FAIL sb_pops got %0d want 4", pops); end
    endtask

    task automatic test_masking;
        exp_w[0] = 32'hAAAA0001; exp_w[1] = 32'hBBBB0002;
        exp_w[2] = 32'hCCCC0003; exp_w[3] = 32'hDDDD0004;
        load_buf(4);
        buf_mask[1] = 4'b1001;
        write = 1'b1;
        for (int c = 0; c < 9; c++) begin
            logic [3:0] e_dm;
            e_dm = (c == 4) ? 4'b1001 : ((c >= 3 && c <= 6) ? 4'b0000 : 4'b1111);
            checks++;
            if ({dm_d0, dm_d1} !== e_dm) begin errors++; $display("FAIL mask_dm c%0d got %b want %b", c, {dm_d0, dm_d1}, e_dm); end
            if (c == 4) begin
                checks++;
                if ({dq_d0, dq_d1} !== 32'hBBBB0002) begin
                    errors++; $display("FAIL mask_dq got %h want bbbb0002", {dq_d0, dq_d1});
                end
            end
            tick();
            write = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) exp_w[i] = {16'(16'h1000 + i), 16'(16'hF000 + i)};
        load_buf(8);
        write = 1'b1;
        for (int c = 0; c < 17; c++) begin
            logic e_rdy, e_req, e_dqoe, e_done;
            logic [31:0] e_dq;
            e_rdy  = (c == 0) || (c == 7) || (c >= 14);
            e_req  = ((c >= 2) && (c <= 5)) || ((c >= 9) && (c <= 12));
            e_dqoe = ((c >= 3) && (c <= 6)) || ((c >= 10) && (c <= 13));
            e_done = (c == 7) || (c == 14);
            e_dq   = (c >= 3 && c <= 6) ? exp_w[c-3] : ((c >= 10 && c <= 13) ? exp_w[c-6] : 32'h0);
            checks++;
            if ({ready, wdata_req, dq_oe, done} !== {e_rdy, e_req, e_dqoe, e_done}) begin
                errors++; $display("FAIL b2b_ctrl c%0d got %b want %b", c, {ready, wdata_req, dq_oe, done}, {e_rdy, e_req, e_dqoe, e_done});
            end
            checks++;
            if ({dq_d0, dq_d1} !== e_dq) begin errors++; $display("FAIL b2b_dq c%0d got %h want %h", c, {dq_d0, dq_d1}, e_dq); end
            if (c == 9) begin
                checks++;
                if ({dqs_oe, dq_oe} !== 2'b10) begin errors++; $display("FAIL b2b_pre got %b want 10", {dqs_oe, dq_oe}); end
            end
            tick();
            write = (c + 1 == 7);
        end
        checks++;
        if (pops !== 8) begin errors++; $display("FAIL b2b_pops got %0d want 8", pops); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", err); end
    endtask

    task automatic test_illegal_write;
        exp_w[0] = 32'h0A0A0B0B; exp_w[1] = 32'h0C0C0D0D;
        exp_w[2] = 32'h0E0E0F0F; exp_w[3] = 32'h12345678;
        load_buf(4);
        write = 1'b1;
        for (int c = 0; c < 11; c++) begin
            logic e_err;
            logic [31:0] e_dq;
            e_err = (c >= 4);
            e_dq  = (c >= 3 && c <= 6) ? exp_w[c-3] : 32'h0;
            checks++;
            if (err !== e_err) begin errors++; $display("FAIL ill_err c%0d got %b want %b", c, err, e_err); end
            checks++;
            if ({dq_d0, dq_d1} !== e_dq) begin errors++; $display("FAIL ill_dq c%0d got %h want %h", c, {dq_d0, dq_d1}, e_dq); end
            checks++;
            if (done !== (c == 7)) begin errors++; $display("FAIL ill_done c%0d got %b want %b", c, done, (c == 7)); end
            tick();
            write = (c + 1 == 3);
        end
        checks++;
        if (pops !== 4) begin errors++; $display("FAIL ill_pops got %0d want 4", pops); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear got %b want 0", err); end
        tick();
    endtask

    task automatic test_reset_mid_data;
        exp_w[0] = 32'h01010202; exp_w[1] = 32'h03030404;
        exp_w[2] = 32'h05050606; exp_w[3] = 32'h07070808;
        load_buf(4);
        write = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 4) begin
                checks++;
                if ({dq_d0, dq_d1} !== 32'h03030404) begin
                    errors++; $display("FAIL mid_dq4 got %h want 03030404", {dq_d0, dq_d1});
                end
                rst_n = 1'b0;
            end
            if (c == 5) begin
                checks++;
                if ({dq_oe, dqs_oe, ready, wdata_req, dm_d0, dm_d1} !== 8'b00101111) begin
                    errors++; $display("FAIL mid_abort got %b want 00101111", {dq_oe, dqs_oe, ready, wdata_req, dm_d0, dm_d1});
                end
                rst_n = 1'b1;
            end
            if (c >= 5) begin
                checks++;
                if ({done, wdata_req} !== 2'b00) begin
                    errors++; $display("FAIL mid_quiet c%0d got %b want 00", c, {done, wdata_req});
                end
            end
            tick();
            write = 1'b0;
        end
        checks++;
        if (pops !== 3) begin errors++; $display("FAIL mid_pops got %0d want 3", pops); end
    endtask

    task automatic test_wl1;
        wdata1 = 32'hCAFEBEEF; wmask1 = 4'b0110;
        write1 = 1'b1;
        tick();
        write1 = 1'b0;
        tick();
        tick();
        // abort the first burst in DATA, then run a clean one
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        write1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            logic e_rdy, e_req, e_dqoe, e_dqsoe, e_done;
            logic [35:0] e_dat;
            e_rdy   = (c == 0) || (c >= 6);
            e_req   = (c >= 1) && (c <= 4);
            e_dqoe  = (c >= 2) && (c <= 5);
            e_dqsoe = (c >= 1) && (c <= 6);
            e_done  = (c == 6);
            e_dat   = e_dqoe ? {32'hCAFEBEEF, 4'b0110} : {32'h0, 4'b1111};
            checks++;
            if ({ready1, wdata_req1, dq_oe1, dqs_oe1, done1} !== {e_rdy, e_req, e_dqoe, e_dqsoe, e_done}) begin
                errors++; $display("FAIL wl1_ctrl c%0d got %b want %b", c, {ready1, wdata_req1, dq_oe1, dqs_oe1, done1}, {e_rdy, e_req, e_dqoe, e_dqsoe, e_done});
            end
            checks++;
            if ({dq_d0_1, dq_d1_1, dm_d0_1, dm_d1_1} !== e_dat) begin
                errors++; $display("FAIL wl1_data c%0d got %h want %h", c, {dq_d0_1, dq_d1_1, dm_d0_1, dm_d1_1}, e_dat);
            end
            tick();
            write1 = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            buf_data[i] = 32'h0;
            buf_mask[i] = 4'h0;
        end
        wdata1 = 32'h0; wmask1 = 4'h0;
        test_reset();
        test_single_burst();
        test_masking();
        test_back_to_back();
        test_illegal_write();
        test_reset_mid_data();
        test_wl1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
